// File: rtl/parking_gate_arbiter_pkg.sv
// ============================================================================
// parking_pkg : shared types and sizing constants for the parking gate arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package parking_pkg;

   localparam int N_SPOTS = 4;
   localparam int IDX_W   = 2;
   localparam int CNT_W   = 3;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTRY_OPEN = 2'd1,
      EXIT_OPEN  = 2'd2
   } gate_state_t;

   typedef enum logic {
      EXIT_FIRST  = 1'b0,
      ENTRY_FIRST = 1'b1
   } prio_t;

endpackage

`default_nettype wire

// File: rtl/parking_gate_arbiter_spot_allocator.sv
// ============================================================================
// spot_allocator : lowest free spot, empty count and full flag from the bitmap
// Revision       : 1.0
// ============================================================================
`default_nettype none

module spot_allocator #(
   parameter int N_SPOTS = parking_pkg::N_SPOTS,
   parameter int IDX_W   = parking_pkg::IDX_W,
   parameter int CNT_W   = parking_pkg::CNT_W
) (
   input  logic [N_SPOTS-1:0] parked,
   output logic [IDX_W-1:0]   first_free,
   output logic [CNT_W-1:0]   empty,
   output logic               full
);
   import parking_pkg::*;

   logic [IDX_W-1:0] w_first_free;
   logic [CNT_W-1:0] w_empty;

   // Scan from the top down so the lowest free index is the last one written.
   always_comb begin
      w_first_free = '0;
      for (int i = N_SPOTS - 1; i >= 0; i--) begin
         if (!parked[i]) begin
            w_first_free = IDX_W'(i);
         end
      end
   end

   always_comb begin
      w_empty = '0;
      for (int i = 0; i < N_SPOTS; i++) begin
         if (!parked[i]) begin
            w_empty = w_empty + CNT_W'(1);
         end
      end
   end

   assign first_free = w_first_free;
   assign empty      = w_empty;
   assign full       = &parked;

endmodule

`default_nettype wire

// File: rtl/parking_gate_arbiter.sv
// ============================================================================
// parking_gate_arbiter : shared barrier arbitration between entry and exit
// lanes with a registered spot-occupancy bitmap. Revision : 1.0
// ============================================================================
`default_nettype none

module parking_gate_arbiter #(
   parameter int N_SPOTS     = parking_pkg::N_SPOTS,
   parameter int GATE_CYCLES = 3,
   parameter int IDX_W       = parking_pkg::IDX_W,
   parameter int CNT_W       = parking_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               entry_req,
   input  logic               exit_req,
   input  logic [IDX_W-1:0]   exit_spot,
   output logic               entry_grant,
   output logic               exit_grant,
   output logic [IDX_W-1:0]   assigned_spot,
   output logic               gate_open,
   output logic               entry_reject,
   output logic               exit_error,
   output logic [N_SPOTS-1:0] parked,
   output logic [CNT_W-1:0]   empty,
   output logic               full
);
   import parking_pkg::*;

   localparam int TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [TMR_W-1:0] c_tmr_load = TMR_W'(GATE_CYCLES - 1);

   generate
      if (GATE_CYCLES < 1 || IDX_W != $clog2(N_SPOTS) || CNT_W != $clog2(N_SPOTS + 1)) begin : g_bad_params
         $error("parking_gate_arbiter: inconsistent parameters");
      end
   endgenerate

   gate_state_t        r_state;
   prio_t              r_prio;
   logic [TMR_W-1:0]   r_timer;
   logic [N_SPOTS-1:0] r_parked;
   logic [IDX_W-1:0]   r_assigned_spot;
   logic               r_entry_grant;
   logic               r_exit_grant;
   logic               r_gate_open;
   logic               r_entry_reject;
   logic               r_exit_error;

   logic [IDX_W-1:0]   w_first_free;
   logic [CNT_W-1:0]   w_empty;
   logic               w_full;
   logic               w_exit_hit;
   logic               w_entry_valid;
   logic               w_exit_valid;
   logic               w_serve_exit;
   logic               w_serve_entry;

   spot_allocator #(
      .N_SPOTS (N_SPOTS),
      .IDX_W   (IDX_W),
      .CNT_W   (CNT_W)
   ) u_spot_allocator (
      .parked     (r_parked),
      .first_free (w_first_free),
      .empty      (w_empty),
      .full       (w_full)
   );

   assign w_exit_hit    = r_parked[exit_spot];
   assign w_entry_valid = entry_req & ~w_full;
   assign w_exit_valid  = exit_req & w_exit_hit;
   // On contention the priority flag picks the side; otherwise whichever is valid.
   assign w_serve_exit  = w_exit_valid & (~w_entry_valid | (r_prio == EXIT_FIRST));
   assign w_serve_entry = w_entry_valid & ~w_serve_exit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= IDLE;
         r_prio          <= EXIT_FIRST;
         r_timer         <= '0;
         r_parked        <= '0;
         r_assigned_spot <= '0;
         r_entry_grant   <= 1'b0;
         r_exit_grant    <= 1'b0;
         r_gate_open     <= 1'b0;
         r_entry_reject  <= 1'b0;
         r_exit_error    <= 1'b0;
      end else begin
         r_entry_grant  <= 1'b0;
         r_exit_grant   <= 1'b0;
         r_entry_reject <= 1'b0;
         r_exit_error   <= 1'b0;
         case (r_state)
            IDLE: begin
               // A full lot with a valid exit pending is not a reject: the exit
               // frees a spot and the entry simply retries.
               r_entry_reject <= entry_req & w_full & ~w_exit_valid;
               r_exit_error   <= exit_req & ~w_exit_hit;
               if (w_serve_entry) begin
                  r_state                <= ENTRY_OPEN;
                  r_entry_grant          <= 1'b1;
                  r_assigned_spot        <= w_first_free;
                  r_parked[w_first_free] <= 1'b1;
                  r_gate_open            <= 1'b1;
                  r_timer                <= c_tmr_load;
                  r_prio                 <= EXIT_FIRST;
               end else if (w_serve_exit) begin
                  r_state             <= EXIT_OPEN;
                  r_exit_grant        <= 1'b1;
                  r_parked[exit_spot] <= 1'b0;
                  r_gate_open         <= 1'b1;
                  r_timer             <= c_tmr_load;
                  r_prio              <= ENTRY_FIRST;
               end
            end
            ENTRY_OPEN, EXIT_OPEN: begin
               if (r_timer == '0) begin
                  r_state     <= IDLE;
                  r_gate_open <= 1'b0;
               end else begin
                  r_timer <= r_timer - TMR_W'(1);
               end
            end
            default: begin
               r_state     <= IDLE;
               r_gate_open <= 1'b0;
            end
         endcase
      end
   end

   assign entry_grant   = r_entry_grant;
   assign exit_grant    = r_exit_grant;
   assign assigned_spot = r_assigned_spot;
   assign gate_open     = r_gate_open;
   assign entry_reject  = r_entry_reject;
   assign exit_error    = r_exit_error;
   assign parked        = r_parked;
   assign empty         = w_empty;
   assign full          = w_full;

endmodule

`default_nettype wire

// File: doc/parking_gate_arbiter.md
Name: parking_gate_arbiter

Overview:
Controller for the single shared barrier gate of the smart-parking lot. It arbitrates between the entry lane and the exit lane and keeps the registered occupancy bitmap of the parking spots. It allocates the lowest-numbered free spot to each entering car and frees the spot of each leaving car. It publishes the live empty-spot count that the display/counter logic consumes.

Parameters:
N_SPOTS, 4, number of parking spots (occupancy bitmap width)
GATE_CYCLES, 3, cycles gate_open stays high per granted passage (>=1)
IDX_W, 2, width of a spot index, equal to clog2(N_SPOTS)
CNT_W, 3, width of the empty count, equal to clog2(N_SPOTS+1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
entry_req  in  1  car waiting at entry; level; sampled only in IDLE
exit_req  in  1  car waiting at exit; level; sampled only in IDLE
exit_spot  in  IDX_W  spot the exiting car vacates; valid with exit_req
entry_grant  out  1  one-cycle pulse: entry passage granted
exit_grant  out  1  one-cycle pulse: exit passage granted
assigned_spot  out  IDX_W  spot given to last entry; held until next entry grant
gate_open  out  1  barrier open
entry_reject  out  1  one-cycle pulse: lot full, entry refused
exit_error  out  1  one-cycle pulse: exit_spot not occupied
parked  out  N_SPOTS  occupancy bitmap, 1 = occupied
empty  out  CNT_W  N_SPOTS minus popcount(parked)
full  out  1  all spots occupied

Behaviour:
- Reset (clk edge with rst=1), next cycle:
  - state=IDLE, parked=0, empty=N_SPOTS, full=0, gate_open=0
  - all pulses 0, assigned_spot=0, priority=EXIT_FIRST, timer=0
- rst mid-passage aborts it: the gate closes on the next cycle and occupancy clears.
- States: IDLE, ENTRY_OPEN, EXIT_OPEN.
- IDLE request qualification:
  - Entry is valid iff entry_req and !full.
  - Exit is valid iff exit_req and parked[exit_spot].
- IDLE arbitration:
  - Both valid: serve the side named by priority. After each grant, priority flips to the other side (round-robin).
  - One valid: serve it.
- Entry grant, at the edge:
  - state=ENTRY_OPEN; entry_grant=1 for one cycle.
  - assigned_spot=lowest index with parked=0; that parked bit is set.
  - gate_open=1; timer=GATE_CYCLES-1.
- Exit grant, at the edge:
  - state=EXIT_OPEN; exit_grant=1 for one cycle.
  - parked[exit_spot] cleared; gate_open=1; timer loaded the same way.
- OPEN states:
  - Timer decrements each cycle. At timer==0 the next edge returns to IDLE and drops gate_open.
  - gate_open is therefore high for exactly GATE_CYCLES cycles.
  - IDLE lasts at least 1 cycle between passages.
- Latency: request seen in IDLE at edge t gives grant and gate_open high from cycle t+1.
- Requests in OPEN states are ignored, not queued. Requesters drop req on grant; a still-high req is a new request.
- entry_reject:
  - Pulses in IDLE when entry_req and full and no valid exit is requested that cycle.
  - If a valid exit is present, the exit is served and no reject is issued; the entry retries.
- exit_error:
  - Pulses in IDLE when exit_req and !parked[exit_spot]; no grant and no bitmap change.
  - A valid entry in the same cycle is still granted.
- Pulse outputs are registered; parked and assigned_spot are registered.
- empty and full are combinational from the registered parked.
- Width rule: empty never exceeds N_SPOTS or underflows. The bitmap only changes on grants, so 0 <= empty <= N_SPOTS always holds.

Decomposition:
- Shared package parking_pkg:
  - gate_state_t enum {IDLE, ENTRY_OPEN, EXIT_OPEN}
  - prio_t enum {EXIT_FIRST, ENTRY_FIRST}
  - constants N_SPOTS, IDX_W, CNT_W
- One sub-module spot_allocator (combinational) takes parked and produces:
  - first_free index
  - full
  - empty count
- Top level holds the FSM, timer, priority flag and registers.

Test Plan:
- Reset, single entry_req pulse -> next cycle entry_grant=1, assigned_spot=0, parked=0001, empty=3, gate_open high 3 cycles then 0.
- Four sequential entries -> assigned_spot 0,1,2,3; parked=1111, empty=0, full=1. A fifth entry_req -> entry_reject pulse, no gate.
- parked=1111, entry_req and exit_req(exit_spot=2) together -> exit_grant, parked=1011, no entry_reject. The held entry is then granted spot 2.
- parked=0011, both valid continuously -> grants alternate exit, entry, exit, entry (starting exit after reset), each separated by 3 open cycles plus 1 IDLE.
- parked=0001, exit_req with exit_spot=3 and entry_req -> exit_error pulse, entry_grant with spot 1, parked=0011.
- rst asserted in 2nd cycle of ENTRY_OPEN -> next cycle gate_open=0, parked=0000, empty=4, state IDLE.
